// File: rtl/pixel_array_sequencer.sv
// pixel_array_sequencer: frame sequencer for the 2x2 pixel array (erase, expose, ramp convert, row readout)
module pixel_array_sequencer #(
  parameter int ERASE_CYCLES = 5,
  parameter int READ_CYCLES  = 2,
  parameter int COUNT_W      = 8,
  parameter int COUNT_MAX    = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         expose_time,
  output logic               pixel_erase,
  output logic               mem_reset,
  output logic               pixel_expose,
  output logic [1:0]         mem_read,
  output logic               bias_en,
  output logic               ramp_en,
  output logic               cnt_drive_en,
  output logic [COUNT_W-1:0] cnt_data,
  output logic               sample_valid,
  output logic               row_idx,
  output logic               busy,
  output logic               done
);
  localparam int A  = ERASE_CYCLES > 2 * READ_CYCLES ? ERASE_CYCLES : 2 * READ_CYCLES;
  localparam int B  = COUNT_MAX + 1 > 256 ? COUNT_MAX + 1 : 256;
  localparam int M  = A > B ? A : B;
  localparam int CW = $clog2(M) + 1;
  localparam int TW = CW > COUNT_W ? CW : COUNT_W + 1;

  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ, DONE} state_t;

  state_t        state, state_n;
  logic [TW-1:0] cnt, cnt_n, cnt_inc;
  logic [7:0]    exp_len;
  logic          last;
  logic          row2;

  assign cnt_inc = cnt + 1'b1;
  assign row2    = cnt_n >= TW'(READ_CYCLES);

  // next state: each phase ends when its cycle counter reaches its length; abort always wins
  always_comb begin
    last    = 1'b0;
    state_n = state;
    case (state)
      IDLE: begin
        last    = start;
        state_n = start ? ERASE : IDLE;
      end
      ERASE: begin
        last    = cnt_inc == TW'(ERASE_CYCLES);
        state_n = last ? EXPOSE : ERASE;
      end
      EXPOSE: begin
        last    = cnt_inc == TW'(exp_len);
        state_n = last ? CONVERT : EXPOSE;
      end
      CONVERT: begin
        last    = cnt == TW'(COUNT_MAX);
        state_n = last ? READ : CONVERT;
      end
      READ: begin
        last    = cnt_inc == TW'(2 * READ_CYCLES);
        state_n = last ? DONE : READ;
      end
      default: begin
        last    = 1'b1;
        state_n = IDLE;
      end
    endcase
    if (abort) state_n = IDLE;
    cnt_n = (last || abort || state == IDLE) ? '0 : cnt_inc;
  end

  // state and phase counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // exposure length latched on an accepted start; zero is stretched to one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) exp_len <= '0;
    else if (state == IDLE && start && !abort) exp_len <= expose_time == 8'd0 ? 8'd1 : expose_time;
  end

  // outputs decoded from the upcoming state so they line up with it; one state drives the bus at a time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_erase  <= 1'b0;
      mem_reset    <= 1'b0;
      pixel_expose <= 1'b0;
      mem_read     <= 2'b00;
      bias_en      <= 1'b0;
      ramp_en      <= 1'b0;
      cnt_drive_en <= 1'b0;
      cnt_data     <= '0;
      sample_valid <= 1'b0;
      row_idx      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      pixel_erase  <= state_n == ERASE;
      mem_reset    <= state_n == ERASE;
      pixel_expose <= state_n == EXPOSE;
      mem_read     <= state_n != READ ? 2'b00 : row2 ? 2'b01 : 2'b10;
      bias_en      <= state_n inside {ERASE, EXPOSE, CONVERT};
      ramp_en      <= state_n == CONVERT;
      cnt_drive_en <= state_n == CONVERT;
      cnt_data     <= state_n == CONVERT ? cnt_n[COUNT_W-1:0] : '0;
      sample_valid <= state_n == READ &&
                      (cnt_n == TW'(READ_CYCLES - 1) || cnt_n == TW'(2 * READ_CYCLES - 1));
      row_idx      <= state_n == READ && row2;
      busy         <= state_n != IDLE;
      done         <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_pixel_array_sequencer.sv
// tb_pixel_array_sequencer: randomized frames checked against a phase-timeline model and an event scoreboard
module tb_pixel_array_sequencer;
  localparam int E = 5;
  localparam int R = 2;
  localparam int C = 256;

  typedef struct packed {
    logic       erase;
    logic       mrst;
    logic       expose;
    logic [1:0] rd;
    logic       bias;
    logic       ramp;
    logic       drv;
    logic [7:0] data;
    logic       sv;
    logic       row;
    logic       busy;
    logic       done;
  } outs_t;

  typedef struct {
    int cyc;
    bit is_done;
    bit row;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expose_time = 8'd0;
  logic       pixel_erase, mem_reset, pixel_expose, bias_en, ramp_en, cnt_drive_en;
  logic       sample_valid, row_idx, busy, done;
  logic [1:0] mem_read;
  logic [7:0] cnt_data;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  t0 = 0;
  int  xq = 1;
  bit  active = 1'b0;
  ev_t sbq[$];

  always #5 clk = ~clk;

  pixel_array_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .expose_time(expose_time),
    .pixel_erase(pixel_erase), .mem_reset(mem_reset), .pixel_expose(pixel_expose),
    .mem_read(mem_read), .bias_en(bias_en), .ramp_en(ramp_en), .cnt_drive_en(cnt_drive_en),
    .cnt_data(cnt_data), .sample_valid(sample_valid), .row_idx(row_idx), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  task automatic cyc_wait();
    @(negedge clk);
    #1;
  endtask

  // expected outputs t cycles after the accepting edge, from the frame timeline
  function automatic outs_t model(input int t, input int x);
    outs_t o;
    int cs, rs, ds, k;
    o  = '0;
    cs = E + x;
    rs = cs + C;
    ds = rs + 2 * R;
    o.busy = 1'b1;
    if (t < E) begin
      o.erase = 1'b1;
      o.mrst  = 1'b1;
      o.bias  = 1'b1;
    end else if (t < cs) begin
      o.expose = 1'b1;
      o.bias   = 1'b1;
    end else if (t < rs) begin
      o.ramp = 1'b1;
      o.bias = 1'b1;
      o.drv  = 1'b1;
      o.data = 8'(t - cs);
    end else if (t < ds) begin
      k    = t - rs;
      o.row = k >= R;
      o.rd  = o.row ? 2'b01 : 2'b10;
      o.sv  = (k % R) == R - 1;
    end else begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  // reference frame tracker: accepts starts, retires frames, and schedules expected events
  always @(posedge clk) begin
    int d;
    cyc++;
    if (!reset) begin
      active = 1'b0;
      sbq.delete();
    end else if (active && (abort || cyc - t0 > E + xq + C + 2 * R)) begin
      active = 1'b0;
      sbq.delete();
    end else if (!active && start && !abort) begin
      active = 1'b1;
      t0 = cyc;
      xq = expose_time == 8'd0 ? 1 : int'(expose_time);
      d  = E + xq + C + 2 * R;
      sbq.push_back('{t0 + E + xq + C + R - 1, 1'b0, 1'b0});
      sbq.push_back('{t0 + d - 1, 1'b0, 1'b1});
      sbq.push_back('{t0 + d, 1'b1, 1'b0});
    end
  end

  // monitor: full output compare every cycle, and scoreboard pop on each sample/done event
  always @(negedge clk) begin
    outs_t a, e;
    ev_t ev;
    a = {pixel_erase, mem_reset, pixel_expose, mem_read, bias_en, ramp_en, cnt_drive_en,
         cnt_data, sample_valid, row_idx, busy, done};
    e = (active && reset) ? model(cyc - t0, xq) : outs_t'(0);
    chk("outputs", 32'(a), 32'(e));
    chk("contention", 32'(cnt_drive_en && mem_read != 2'b00), 32'd0);
    chk("read_11", 32'(mem_read == 2'b11), 32'd0);
    if (sample_valid || done) begin
      if (sbq.size() == 0) chk("unexpected_event", 32'({done, sample_valid}), 32'd0);
      else begin
        ev = sbq.pop_front();
        chk(done ? "done_cycle" : "sample_cycle", cyc, ev.cyc);
        chk("event_kind", 32'(done), 32'(ev.is_done));
        if (!done) chk("sample_row", 32'(row_idx), 32'(ev.row));
      end
    end
  end

  task automatic run_frame(input logic [7:0] x, input int want_lat, input bit spur);
    int acc, n_er, n_ex, lat;
    n_er = 0;
    n_ex = 0;
    lat  = -1;
    expose_time = x;
    start = 1'b1;
    acc = cyc + 1;
    cyc_wait();
    start = 1'b0;
    expose_time = 8'($urandom);
    for (int i = 0; i < 700; i++) begin
      if (pixel_erase) n_er++;
      if (pixel_expose) n_ex++;
      start = spur && pixel_expose && n_ex == 2;
      if (done) begin
        lat = cyc - acc + 1;
        break;
      end
      cyc_wait();
    end
    start = 1'b0;
    chk("latency", lat, want_lat);
    chk("erase_len", n_er, E);
    chk("expose_len", n_ex, x == 8'd0 ? 1 : int'(x));
    cyc_wait();
    chk("busy_after_done", 32'(busy), 32'd0);
    cyc_wait();
  endtask

  initial begin
    bit found;
    int x;
    repeat (3) cyc_wait();
    chk("reset_outs", {pixel_erase, mem_reset, pixel_expose, mem_read, bias_en, ramp_en,
                       cnt_drive_en, cnt_data, sample_valid, row_idx, busy, done}, 32'd0);
    reset = 1'b1;
    repeat (2) cyc_wait();

    run_frame(8'd10, 276, 1'b0);
    run_frame(8'd0, 267, 1'b0);
    run_frame(8'd10, 276, 1'b1);

    start = 1'b1;
    abort = 1'b1;
    cyc_wait();
    chk("start_abort_idle", 32'(busy), 32'd0);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) cyc_wait();

    expose_time = 8'd10;
    start = 1'b1;
    cyc_wait();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cnt_drive_en && cnt_data == 8'd100) begin
        found = 1'b1;
        break;
      end
      cyc_wait();
    end
    chk("wait_cnt100", 32'(found), 32'd1);
    abort = 1'b1;
    cyc_wait();
    abort = 1'b0;
    chk("abort_idle", {busy, bias_en, ramp_en, cnt_drive_en, cnt_data, done}, 32'd0);
    repeat (5) cyc_wait();
    run_frame(8'd10, 276, 1'b0);

    for (int n = 0; n < 5; n++) begin
      x = $urandom_range(0, 30);
      run_frame(8'(x), 1 + E + (x == 0 ? 1 : x) + C + 2 * R, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) cyc_wait();
    end

    expose_time = 8'd3;
    start = 1'b1;
    cyc_wait();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (mem_read != 2'b00) begin
        found = 1'b1;
        break;
      end
      cyc_wait();
    end
    chk("wait_read", 32'(found), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", {mem_read, busy, sample_valid}, 32'd0);
    repeat (2) cyc_wait();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc_wait();
      chk("idle_after_reset", 32'(busy), 32'd0);
    end
    run_frame(8'd4, 1 + E + 4 + C + 2 * R, 1'b0);

    repeat (3) cyc_wait();
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pixel_array_sequencer.md
Name: pixel_array_sequencer

Overview:
- Top-level sequencer for the 2x2 pixel sensor array.
- Runs one full frame: erase, expose, ramp conversion, then row-by-row readout. During readout the array drives the shared column data buses.
- Drives the array control pins (erase, expose, mem_reset, mem_read) and the ramp/bias enables.
- During conversion it drives the Gray-free binary ramp counter onto the column buses. Each pixel memory latches the counter value when its comparator trips.

Parameters:
- ERASE_CYCLES, 5, cycles pixel_erase/mem_reset held high (min 1)
- READ_CYCLES, 2, cycles each row's mem_read is held (min 1)
- COUNT_W, 8, ramp counter / data bus width
- COUNT_MAX, 255, last conversion count (must be < 2**COUNT_W)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  frame request, sampled only in IDLE
- abort  in  1  synchronous abort, any state
- expose_time  in  8  exposure length in cycles, latched on accepted start
- pixel_erase  out  1  to array PIXELERASE
- mem_reset  out  1  to array MEMRESET
- pixel_expose  out  1  to array EXPOSE
- mem_read  out  2  to array READ; bit1 = row 1, bit0 = row 2
- bias_en  out  1  enables external VBN1 bias clock
- ramp_en  out  1  enables external ramp clock
- cnt_drive_en  out  1  tri-state enable of counter onto both pixData buses
- cnt_data  out  COUNT_W  ramp counter value
- sample_valid  out  1  pixData1/pixData2 valid for the current row
- row_idx  out  1  row being read (0 = row 1, 1 = row 2)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle frame-complete pulse

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0, all counters 0, expose_time register 0.
- All outputs are registered and change only on the clk rising edge.
- States: IDLE -> ERASE -> EXPOSE -> CONVERT -> READ -> DONE -> IDLE.
- IDLE:
  - All outputs 0.
  - start=1 and abort=0 -> latch exp = (expose_time==0 ? 1 : expose_time), go to ERASE.
  - start and abort together in IDLE: abort wins, stay IDLE.
- ERASE:
  - pixel_erase=1, mem_reset=1, bias_en=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE:
  - pixel_expose=1, bias_en=1 for exactly exp cycles, then CONVERT.
- CONVERT:
  - ramp_en=1, bias_en=1, cnt_drive_en=1.
  - cnt_data steps 0,1,...,COUNT_MAX, one value per cycle (COUNT_MAX+1 cycles).
  - After COUNT_MAX go to READ; the counter never wraps.
  - cnt_data is held at 0 whenever cnt_drive_en=0.
- READ:
  - cnt_drive_en=0 in the same cycle mem_read goes nonzero. No cycle may have both active, to avoid bus contention.
  - Row 1 first: mem_read=2'b10, row_idx=0 for READ_CYCLES cycles. Then row 2: mem_read=2'b01, row_idx=1 for READ_CYCLES cycles.
  - mem_read is never 2'b11.
  - sample_valid=1 on the last cycle of each row window only.
- DONE:
  - One cycle with done=1, busy=1, all array controls 0. Then IDLE.
- busy: 1 in every state except IDLE; 0 in the cycle after DONE.
- abort=1 in any non-IDLE state: the next state is IDLE.
  - All outputs 0 on the following cycle.
  - All counters are cleared and done is not asserted.
- start is ignored while busy; no queuing.
- Frame latency from the accepted-start edge to done high: 1 + ERASE_CYCLES + exp + (COUNT_MAX+1) + 2*READ_CYCLES cycles.
- Reset asserted mid-frame: immediate return to IDLE values regardless of clk.

Test Plan:
- Reset then start=1, expose_time=10, defaults:
  - pixel_erase high 5 cycles, pixel_expose high 10, cnt_data 0..255 over 256 cycles, mem_read 10 x2 then 01 x2.
  - done pulses exactly 276 cycles after the start edge; busy low the next cycle.
- expose_time=0 -> pixel_expose high exactly 1 cycle; total latency 267.
- Contention check over a full frame:
  - cnt_drive_en & |mem_read is never 1.
  - mem_read is never 2'b11.
  - sample_valid is high only on the 2nd cycle of each row window, with row_idx 0 then 1.
- abort=1 at cnt_data=100 -> next cycle all outputs 0, state IDLE, no done. A new start then runs a full 276-cycle frame.
- start pulsed during EXPOSE, and start together with abort in IDLE -> both ignored; frame timing unchanged, busy stays 0 in the abort case.
- reset low mid-READ (asynchronous, between clk edges) -> mem_read, busy and sample_valid go 0 immediately. After release, no activity until start.
